// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debounce / one-hot latch front end.
package key_debounce_pkg;

  localparam int NUM_KEYS = 6;

  typedef enum logic [1:0] {IDLE, HELD, INVALID} key_state_t;

  // True when exactly one bit of the key vector is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises a raw key vector and accepts it only after it has held
// steady for DEBOUNCE_CYCLES consecutive clocks.
module debounce_filter
  import key_debounce_pkg::*;
#(
  parameter int DATA_W          = NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] btn_raw,
  output logic [DATA_W-1:0] stable
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] btn_p0;
  logic [DATA_W-1:0] sync_p1;
  logic [DATA_W-1:0] sync_p2;
  logic [DATA_W-1:0] cand_p3;
  logic [CNT_W-1:0]  cnt_p3;
  logic [DATA_W-1:0] stable_p4;

  // Stage 0: normalise polarity so a pressed key is always 1
  assign btn_p0 = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Stages 1-2: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= btn_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Stages 3-4: candidate tracking with a saturating stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_p3   <= '0;
      cnt_p3    <= '0;
      stable_p4 <= '0;
    end else if (sync_p2 != cand_p3) begin
      cand_p3 <= sync_p2;
      cnt_p3  <= '0;
    end else if (cnt_p3 == CNT_MAX) begin
      stable_p4 <= cand_p3;
    end else begin
      cnt_p3 <= cnt_p3 + CNT_W'(1);
    end
  end

  assign stable = stable_p4;

endmodule

// File: rtl/key_debounce_latch.sv
// Debounced 6-key front end: accepts clean single-key presses and holds the
// last accepted key as a one-hot code for the seven-segment coder.
module key_debounce_latch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn_raw,
  output logic [5:0] key_onehot,
  output logic       key_strobe,
  output logic       key_busy
);

  logic [NUM_KEYS-1:0] stable;
  key_state_t          state;
  key_state_t          state_nxt;
  logic [NUM_KEYS-1:0] onehot_nxt;
  logic                strobe_nxt;

  debounce_filter #(
    .DATA_W          (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .stable  (stable)
  );

  // Only a press starting from all-released can latch; HELD ignores added keys
  always_comb begin
    state_nxt  = state;
    onehot_nxt = key_onehot;
    strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (is_onehot(stable)) begin
          state_nxt  = HELD;
          onehot_nxt = stable;
          strobe_nxt = 1'b1;
        end else if (stable != '0) begin
          state_nxt = INVALID;
        end
      end
      HELD, INVALID: begin
        if (stable == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 5: registered FSM state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_onehot <= '0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      key_onehot <= onehot_nxt;
      key_strobe <= strobe_nxt;
    end
  end

  assign key_busy = (state != IDLE);

endmodule
